// File: rtl/context_fetch.sv
// context_fetch: front end of the JPEG-LS encoder. Accepts a raster-order
// pixel stream, keeps a one-row line buffer and issues the causal template
// (c b d above, a x on the current row) for every accepted pixel.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   pixel_in     current sample, raster order
//   pixel_valid  pixel_in valid this cycle (always accepted)
//   a,b,c,d,x    registered template (Ra, Rb, Rc, Rd, current sample)
//   EOL, EOF     x is last of its row / last of the frame
//   start_enc    one-cycle strobe marking a fresh template
module context_fetch #(
  parameter int unsigned pixel_length = 8,
  parameter int unsigned image_width  = 512,
  parameter int unsigned image_height = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [pixel_length-1:0] pixel_in,
  input  logic                    pixel_valid,
  output logic [pixel_length-1:0] a,
  output logic [pixel_length-1:0] b,
  output logic [pixel_length-1:0] c,
  output logic [pixel_length-1:0] d,
  output logic [pixel_length-1:0] x,
  output logic                    EOL,
  output logic                    EOF,
  output logic                    start_enc
);

  localparam int unsigned COL_W = (image_width  > 1) ? $clog2(image_width)  : 1;
  localparam int unsigned ROW_W = (image_height > 1) ? $clog2(image_height) : 1;
  localparam int unsigned PW    = pixel_length;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PW-1:0]    prev_x_q, prev_x_d;
  logic [PW-1:0]    prev_b_q, prev_b_d;
  logic [PW-1:0]    row_a0_q, row_a0_d;
  logic [PW-1:0]    a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, x_q, x_d;
  logic             eol_q, eol_d, eof_q, eof_d, start_q, start_d;

  // One-row line buffer: holds the previous row, overwritten as we go.
  logic [PW-1:0]    line_q [image_width];

  logic             last_col, last_row;
  logic [COL_W-1:0] col_p1;
  logic [PW-1:0]    b_rd, d_rd;
  logic [PW-1:0]    t_a, t_b, t_c, t_d;

  assign last_col = (col_q == COL_W'(image_width - 1));
  assign last_row = (row_q == ROW_W'(image_height - 1));
  assign col_p1   = col_q + COL_W'(1);
  assign b_rd     = line_q[col_q];
  // col_p1 is only used when it is still inside the row.
  assign d_rd     = last_col ? b_rd : line_q[col_p1];

  // Causal template for the pixel at (row_q, col_q).
  always_comb begin
    t_a = '0;
    t_b = '0;
    t_c = '0;
    t_d = '0;
    if (row_q == '0) begin
      t_a = (col_q == '0) ? '0 : prev_x_q;
    end else begin
      t_b = b_rd;
      t_d = d_rd;
      if (col_q == '0) begin
        t_a = b_rd;
        t_c = row_a0_q;
      end else begin
        t_a = prev_x_q;
        t_c = prev_b_q;
      end
    end
  end

  // Next-state: counters, history and output registers.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    prev_x_d = prev_x_q;
    prev_b_d = prev_b_q;
    row_a0_d = row_a0_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    x_d      = x_q;
    eol_d    = eol_q;
    eof_d    = eof_q;
    start_d  = 1'b0;
    if (pixel_valid) begin
      start_d  = 1'b1;
      a_d      = t_a;
      b_d      = t_b;
      c_d      = t_c;
      d_d      = t_d;
      x_d      = pixel_in;
      eol_d    = last_col;
      eof_d    = last_col && last_row;
      prev_x_d = pixel_in;
      prev_b_d = t_b;
      // Ra issued at a row start becomes Rc at the next row start.
      if (col_q == '0) row_a0_d = t_a;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q    <= '0;
      row_q    <= '0;
      prev_x_q <= '0;
      prev_b_q <= '0;
      row_a0_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      x_q      <= '0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      prev_x_q <= prev_x_d;
      prev_b_q <= prev_b_d;
      row_a0_q <= row_a0_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      x_q      <= x_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      start_q  <= start_d;
    end
  end

  // Line buffer is not reset: row 0 never reads it.
  always_ff @(posedge clk) begin
    if (pixel_valid) line_q[col_q] <= pixel_in;
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign d         = d_q;
  assign x         = x_q;
  assign EOL       = eol_q;
  assign EOF       = eof_q;
  assign start_enc = start_q;

endmodule

// File: tb/tb_context_fetch.sv
// Testbench for context_fetch with a 4x3 frame.
module tb_context_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic [7:0] a, b, c, d, x;
  logic       EOL, EOF, start_enc;

  context_fetch #(.pixel_length(8), .image_width(4), .image_height(3)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .a(a), .b(b), .c(c), .d(d), .x(x), .EOL(EOL), .EOF(EOF), .start_enc(start_enc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    int         idle;
    logic [7:0] ea, eb, ec, ed;
    logic       eol, eof;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  vec_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   sent   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] p, input int idl,
                              input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] ec, input logic [7:0] ed,
                              input logic el, input logic ef);
    vec_t v;
    v.pix = p; v.idle = idl; v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed;
    v.eol = el; v.eof = ef;
    return v;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_a"}, 32'(a), 0);
    chk({nm, "_b"}, 32'(b), 0);
    chk({nm, "_c"}, 32'(c), 0);
    chk({nm, "_d"}, 32'(d), 0);
    chk({nm, "_x"}, 32'(x), 0);
    chk({nm, "_eol"}, 32'(EOL), 0);
    chk({nm, "_eof"}, 32'(EOF), 0);
    chk({nm, "_start"}, 32'(start_enc), 0);
  endtask

  task automatic send(input vec_t v);
    pixel_in    = v.pix;
    pixel_valid = 1'b1;
    sb.push_back(v);
    sent++;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (start_enc) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got x=%0d expected no strobe", x);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("x", 32'(x), 32'(e.pix));
        chk("a", 32'(a), 32'(e.ea));
        chk("b", 32'(b), 32'(e.eb));
        chk("c", 32'(c), 32'(e.ec));
        chk("d", 32'(d), 32'(e.ed));
        chk("eol", 32'(EOL), 32'(e.eol));
        chk("eof", 32'(EOF), 32'(e.eof));
      end
    end
  end

  initial begin
    // pix idle  a   b   c   d  eol eof
    vecs[0]  = mk(10, 0,  0,  0,  0,  0, 0, 0);
    vecs[1]  = mk(20, 0, 10,  0,  0,  0, 0, 0);
    vecs[2]  = mk(30, 0, 20,  0,  0,  0, 0, 0);
    vecs[3]  = mk(40, 0, 30,  0,  0,  0, 1, 0);
    vecs[4]  = mk(11, 0, 10, 10,  0, 20, 0, 0);
    vecs[5]  = mk(21, 0, 11, 20, 10, 30, 0, 0);
    vecs[6]  = mk(31, 0, 21, 30, 20, 40, 0, 0);
    vecs[7]  = mk(41, 0, 31, 40, 30, 40, 1, 0);
    vecs[8]  = mk(12, 0, 11, 11, 10, 21, 0, 0);
    vecs[9]  = mk(22, 2, 12, 21, 11, 31, 0, 0);
    vecs[10] = mk(32, 0, 22, 31, 21, 41, 0, 0);
    vecs[11] = mk(42, 0, 32, 41, 31, 41, 1, 1);
    vecs[12] = mk(99, 0,  0,  0,  0,  0, 0, 0);
    vecs[13] = mk( 5, 0, 99,  0,  0,  0, 0, 0);
    vecs[14] = mk( 6, 0,  5,  0,  0,  0, 0, 0);
    vecs[15] = mk( 7, 0,  6,  0,  0,  0, 1, 0);
    vecs[16] = mk( 8, 0, 99, 99,  0,  5, 0, 0);
    vecs[17] = mk( 9, 0,  8,  5, 99,  6, 0, 0);

    reset       = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("idle_after_reset");

    // Table-driven frame: rows 0..2, frame wrap, then into row 1 of next frame.
    for (int i = 0; i < NV; i++) begin
      send(vecs[i]);
      for (int k = 0; k < vecs[i].idle; k++) begin
        @(posedge clk);
        #1;
        chk("gap_start", 32'(start_enc), 0);
        chk("gap_x", 32'(x), 32'(vecs[i].pix));
        chk("gap_a", 32'(a), 32'(vecs[i].ea));
        chk("gap_b", 32'(b), 32'(vecs[i].eb));
        chk("gap_d", 32'(d), 32'(vecs[i].ed));
      end
    end

    // Mid-frame reset at row 1 col 2, with valid held during reset.
    @(negedge clk);
    #1;
    reset       = 1'b0;
    pixel_in    = 8'd55;
    pixel_valid = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_start", 32'(start_enc), 0);
    chk("reset_hold_x", 32'(x), 0);
    pixel_valid = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    send(mk(7, 0, 0, 0, 0, 0, 0, 0));

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    chk("pulse_count", 32'(pulses), 32'(sent));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
